// File: rtl/iso_addsub_pipe.sv
// iso_addsub_pipe: two-stage, operand-isolated add/sub/accumulate datapath with
// valid/ready handshaking on both sides.
//   Stage 1 registers the opcode and operands, and loads each operand register
//   only for the opcodes that use it.
//   Stage 2 computes the result and commits the accumulator.
// Optional feature macro: ADD_SAT_EN (saturating unsigned arithmetic; default wraps).
module iso_addsub_pipe #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   SEL,
  input  logic [N-1:0] DATA_1,
  input  logic [N-1:0] DATA_2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_flag,
  output logic [N-1:0] acc_q
);

  localparam logic [2:0] OpPassA = 3'b000;
  localparam logic [2:0] OpAdd   = 3'b001;
  localparam logic [2:0] OpSub   = 3'b100;
  localparam logic [2:0] OpAcc   = 3'b101;
  localparam logic [2:0] OpClr   = 3'b110;

  // Stage-1 state
  logic         s1_valid;
  logic [2:0]   s1_op;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic [N-1:0] p1;

  // Handshake and isolation controls
  logic         adv2;
  logic         adv1;
  logic         accept;
  logic         ld_a;
  logic         ld_b;
  logic         ld_p;
  logic [N-1:0] p_next;

  // Stage-2 results
  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N:0]   acc_sum;
  logic [N-1:0] res_data;
  logic         res_flag;
  logic [N-1:0] acc_d;
  logic         acc_we;

  // Pipeline advance conditions; in_ready never depends on in_valid.
  always_comb begin
    adv2     = !out_valid || out_ready;
    adv1     = !s1_valid || adv2;
    in_ready = adv1;
    accept   = in_valid && adv1;
  end

  // Operand-register load enables: arithmetic registers stay frozen on pass/clear
  // ops so the adder inputs do not toggle, and b1 is also frozen on accumulate.
  always_comb begin
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_p   = 1'b0;
    p_next = DATA_1;
    case (SEL)
      OpAdd, OpSub: begin
        ld_a = 1'b1;
        ld_b = 1'b1;
      end
      OpAcc: ld_a = 1'b1;
      OpClr: ;
      3'b010, 3'b011: begin
        ld_p   = 1'b1;
        p_next = DATA_2;
      end
      default: ld_p = 1'b1;  // 000 and reserved 111 pass DATA_1
    endcase
  end

  // Stage-1 register: opcode, valid and gated operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OpPassA;
      a1       <= '0;
      b1       <= '0;
      p1       <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_op <= SEL;
        if (ld_a) a1 <= DATA_1;
        if (ld_b) b1 <= DATA_2;
        if (ld_p) p1 <= p_next;
      end
    end
  end

  // Stage-2 datapath; accumulate always reads the committed acc_q, so
  // back-to-back accumulates chain without forwarding.
  always_comb begin
    sum      = {1'b0, a1} + {1'b0, b1};
    diff     = {1'b0, a1} - {1'b0, b1};
    acc_sum  = {1'b0, acc_q} + {1'b0, a1};
    res_data = p1;
    res_flag = 1'b0;
    acc_d    = acc_q;
    acc_we   = 1'b0;
    case (s1_op)
      OpAdd: begin
`ifdef ADD_SAT_EN
        res_data = sum[N] ? '1 : sum[N-1:0];
`else
        res_data = sum[N-1:0];
`endif
        res_flag = sum[N];
      end
      OpSub: begin
`ifdef ADD_SAT_EN
        res_data = diff[N] ? '0 : diff[N-1:0];
`else
        res_data = diff[N-1:0];
`endif
        res_flag = diff[N];  // borrow: a1 < b1
      end
      OpAcc: begin
`ifdef ADD_SAT_EN
        res_data = acc_sum[N] ? '1 : acc_sum[N-1:0];
`else
        res_data = acc_sum[N-1:0];
`endif
        res_flag = acc_sum[N];
        acc_d    = res_data;
        acc_we   = 1'b1;
      end
      OpClr: begin
        res_data = '0;
        acc_d    = '0;
        acc_we   = 1'b1;
      end
      default: ;  // pass ops use p1 with flag 0
    endcase
  end

  // Stage-2 register: output holds while stalled; accumulator commits with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flag  <= 1'b0;
      acc_q     <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_data;
        out_flag <= res_flag;
        if (acc_we) acc_q <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_iso_addsub_pipe.sv
// Scoreboard bench for iso_addsub_pipe: the driver pushes hand-computed results,
// and the monitor pops and compares on every output handshake.
module tb_iso_addsub_pipe;
  localparam int unsigned N = 32;
`ifdef ADD_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   SEL;
  logic [N-1:0] DATA_1;
  logic [N-1:0] DATA_2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_flag;
  logic [N-1:0] acc_q;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_d_q[$];
  logic         exp_f_q[$];

  iso_addsub_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .SEL(SEL),
    .DATA_1(DATA_1), .DATA_2(DATA_2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flag(out_flag), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Present one item from a negedge and hold it until accepted.
  task automatic send(input logic [2:0] sel, input logic [N-1:0] d1, input logic [N-1:0] d2,
                      input logic [N-1:0] ed, input logic ef);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    SEL      = sel;
    DATA_1   = d1;
    DATA_2   = d2;
    #1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
      in_valid = 1'b0;
    end else begin
      exp_d_q.push_back(ed);
      exp_f_q.push_back(ef);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_d_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain_pending", exp_d_q.size(), 0);
  endtask

  // Monitor: pops on handshake; also flags out_valid dropping while stalled.
  initial begin : monitor
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pv) check("valid_held", out_valid, 1);
        if (out_valid && out_ready) begin
          if (exp_d_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", out_data);
          end else begin
            check("out_data", out_data, exp_d_q.pop_front());
            check("out_flag", out_flag, exp_f_q.pop_front());
          end
        end
        pv = out_valid && !out_ready;
      end else begin
        pv = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0]   pass_ops[4];
    logic [N-1:0] r1;
    logic [N-1:0] r2;
    logic [N-1:0] snap;
    pass_ops[0] = 3'b000;
    pass_ops[1] = 3'b010;
    pass_ops[2] = 3'b011;
    pass_ops[3] = 3'b111;

    rst_n = 1'b0; in_valid = 1'b0; SEL = '0; DATA_1 = '0; DATA_2 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flag", out_flag, 0);
    check("rst_acc_q", acc_q, 0);
    check("rst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;

    // Arithmetic and pass opcodes
    send(3'b001, 32'd5, 32'd7, 32'd12, 1'b0);
    send(3'b001, 32'hFFFF_FFFF, 32'd1, Sat ? 32'hFFFF_FFFF : 32'h0, 1'b1);
    send(3'b100, 32'd3, 32'd5, Sat ? 32'h0 : 32'hFFFF_FFFE, 1'b1);
    send(3'b100, 32'd9, 32'd4, 32'd5, 1'b0);
    send(3'b010, 32'd1, 32'hAA, 32'hAA, 1'b0);
    send(3'b011, 32'd2, 32'hAA, 32'hAA, 1'b0);
    send(3'b000, 32'h33, 32'h44, 32'h33, 1'b0);
    send(3'b111, 32'h55, 32'h66, 32'h55, 1'b0);
    drain();

    // Back-to-back accumulate, then clear
    send(3'b101, 32'd10, 32'd0, 32'd10, 1'b0);
    send(3'b101, 32'd20, 32'd0, 32'd30, 1'b0);
    send(3'b101, 32'd30, 32'd0, 32'd60, 1'b0);
    drain();
    check("acc_after_acc", acc_q, 32'd60);
    send(3'b110, 32'd9, 32'd9, 32'd0, 1'b0);
    drain();
    check("acc_after_clr", acc_q, 32'd0);

    // Isolation: pass ops must leave a1/b1 untouched
    send(3'b001, 32'h1234, 32'h5678, 32'h68AC, 1'b0);
    for (int i = 0; i < 10; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      send(pass_ops[i%4], r1, r2, (pass_ops[i%4] inside {3'b010, 3'b011}) ? r2 : r1, 1'b0);
      check("iso_a1", dut.a1, 32'h1234);
      check("iso_b1", dut.b1, 32'h5678);
    end
    drain();

    // Backpressure: 4 items streamed into a stalled pipe
    set_ready(1'b0);
    fork
      begin
        send(3'b000, 32'hA1, 32'h0, 32'hA1, 1'b0);
        send(3'b101, 32'd7, 32'h0, 32'd7, 1'b0);
        send(3'b011, 32'h0, 32'hB3, 32'hB3, 1'b0);
        send(3'b001, 32'd2, 32'd3, 32'd5, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        #2 snap = out_data;
        repeat (2) @(negedge clk);
        #2;
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", exp_d_q.size(), 2);
        check("stall_out_stable", out_data, snap);
        check("stall_out_head", out_data, 32'hA1);
        check("stall_acc_hold", acc_q, 32'd0);
        set_ready(1'b1);
        #1 check("full_pop_push_ready", in_ready, 1);
      end
    join
    drain();
    check("acc_after_stall", acc_q, 32'd7);

    // Reset with two items in flight
    set_ready(1'b0);
    send(3'b001, 32'd1, 32'd1, 32'd2, 1'b0);
    send(3'b101, 32'd5, 32'd0, 32'd12, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_flag", out_flag, 0);
    check("midrst_acc_q", acc_q, 0);
    check("midrst_a1", dut.a1, 0);
    exp_d_q.delete();
    exp_f_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("postrst_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    check("postrst_acc_q", acc_q, 0);
    send(3'b001, 32'd5, 32'd7, 32'd12, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
